vga_rx_capture: RTL

//  Receive end of the 640x480 VGA pixel interface: consumes hsync/vsync/valid/RGB from a timing

---
 rtl/vga_rx_pkg.sv | 24 ++
 rtl/vga_rx_if.sv | 30 +++
 rtl/vga_rx_capture_sync_edge.sv | 41 ++++
 rtl/vga_rx_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA receive capture block.
// FSM states, default 640x480 timing, err bit positions, sync bit lanes.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  localparam int H_TOTAL_DEF  = 800;
  localparam int V_TOTAL_DEF  = 525;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int ERR_FRAME  = 2;
  localparam int ERR_LINE   = 1;
  localparam int ERR_ACTIVE = 0;

  localparam int SYNC_HS = 0;
  localparam int SYNC_VS = 1;
  localparam int SYNC_DE = 2;

endpackage

// File: rtl/vga_rx_if.sv
// VGA pixel bus from a timing generator to a receiver.
// master drives the sync/valid/colour lines, slave samples them.
interface vga_rx_if;

  logic       hsync;
  logic       vsync;
  logic       valid;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  modport master (
    output hsync,
    output vsync,
    output valid,
    output vga_r,
    output vga_g,
    output vga_b
  );

  modport slave (
    input hsync,
    input vsync,
    input valid,
    input vga_r,
    input vga_g,
    input vga_b
  );

endinterface

// File: rtl/vga_rx_capture_sync_edge.sv
// Two-stage capture of hsync/vsync/valid with edge pulses.
// Edges compare stage 1 (newest) against stage 2.
module vga_sync_edge
  import vga_rx_pkg::*;
(
  input  logic pclk,
  input  logic reset,
  input  logic i_hsync,
  input  logic i_vsync,
  input  logic i_valid,
  output logic o_hs_fall,
  output logic o_vs_fall,
  output logic o_de_rise,
  output logic o_de_fall,
  output logic o_de,
  output logic o_de_d
);

  logic [2:0] r_s1;
  logic [2:0] r_s2;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1[SYNC_HS] <= i_hsync;
      r_s1[SYNC_VS] <= i_vsync;
      r_s1[SYNC_DE] <= i_valid;
      r_s2          <= r_s1;
    end
  end

  assign o_hs_fall = r_s2[SYNC_HS] & ~r_s1[SYNC_HS];
  assign o_vs_fall = r_s2[SYNC_VS] & ~r_s1[SYNC_VS];
  assign o_de_rise = r_s1[SYNC_DE] & ~r_s2[SYNC_DE];
  assign o_de_fall = r_s2[SYNC_DE] & ~r_s1[SYNC_DE];
  assign o_de      = r_s1[SYNC_DE];
  assign o_de_d    = r_s2[SYNC_DE];

endmodule

// File: rtl/vga_rx_capture.sv
// VGA receive capture: pixel coordinates, line/frame timing, lock/err.
// Optional VGA_RX_FRAME_SUM_EN adds a per-frame pixel checksum port.
module vga_rx_capture
  import vga_rx_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        pclk,
  input  logic        reset,
  vga_rx_if.slave     vga,
  input  logic        err_clr,
  output logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] h_period,
  output logic [10:0] v_period,
  output logic [2:0]  err
`ifdef VGA_RX_FRAME_SUM_EN
  ,
  output logic [23:0] frame_sum
`endif
);

  logic w_hs_fall;
  logic w_vs_fall;
  logic w_de_rise;
  logic w_de_fall;
  logic w_de;
  logic w_de_d;

  vga_sync_edge u_sync (
    .pclk      (pclk),
    .reset     (reset),
    .i_hsync   (vga.hsync),
    .i_vsync   (vga.vsync),
    .i_valid   (vga.valid),
    .o_hs_fall (w_hs_fall),
    .o_vs_fall (w_vs_fall),
    .o_de_rise (w_de_rise),
    .o_de_fall (w_de_fall),
    .o_de      (w_de),
    .o_de_d    (w_de_d)
  );

  logic [23:0] r_rgb1;
  logic [23:0] r_rgb2;
  logic [11:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_xc;
  logic [9:0]  r_yc;
  state_t      r_state;
  logic        r_bad;

  logic [11:0] w_h_meas;
  logic [10:0] w_v_line;
  logic [9:0]  w_x_cur;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_inc;
  logic        w_len_bad;
  logic        w_h_bad;
  logic        w_v_bad;
  logic [2:0]  w_err_set;

  // r_x holds the column the next valid pixel will get
  assign w_x_cur = w_de_rise ? 10'd0 : r_x;
  assign w_x_nxt = (w_x_cur == 10'h3FF) ? w_x_cur
                                        : w_x_cur + 10'd1;

  assign w_h_meas = (r_h_cnt == 12'hFFF) ? r_h_cnt
                                         : r_h_cnt + 12'd1;

  // a line edge in the same cycle counts before the frame edge
  assign w_v_line = (w_hs_fall && r_v_cnt != 11'h7FF)
                  ? r_v_cnt + 11'd1 : r_v_cnt;

  assign w_y_inc = (w_de_fall && r_y != 10'h3FF)
                 ? r_y + 10'd1 : r_y;

  assign w_len_bad = w_de_fall && (r_x != 10'(H_ACTIVE));
  assign w_h_bad   = w_hs_fall && (w_h_meas != 12'(H_TOTAL));
  assign w_v_bad   = w_vs_fall &&
                     ((w_v_line != 11'(V_TOTAL)) ||
                      (w_y_inc != 10'(V_ACTIVE)));

  always_comb begin
    w_err_set = '0;
    if (r_state == LOCKED) begin
      w_err_set[ERR_FRAME]  = w_v_bad;
      w_err_set[ERR_LINE]   = w_h_bad;
      w_err_set[ERR_ACTIVE] = w_len_bad;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_rgb1 <= '0;
      r_rgb2 <= '0;
      r_xc   <= '0;
      r_yc   <= '0;
    end else begin
      r_rgb1 <= {vga.vga_r, vga.vga_g, vga.vga_b};
      r_rgb2 <= r_rgb1;
      r_xc   <= w_x_cur;
      r_yc   <= r_y;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_h_cnt  <= '0;
      h_period <= '0;
    end else if (w_hs_fall) begin
      r_h_cnt  <= '0;
      h_period <= w_h_meas;
    end else begin
      r_h_cnt  <= w_h_meas;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_v_cnt  <= '0;
      v_period <= '0;
    end else if (w_vs_fall) begin
      r_v_cnt  <= '0;
      v_period <= w_v_line;
    end else begin
      r_v_cnt  <= w_v_line;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (w_de) begin
        r_x <= w_x_nxt;
      end
      r_y <= w_vs_fall ? 10'd0 : w_y_inc;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_data  <= r_rgb2;
      pix_x     <= r_xc;
      pix_y     <= r_yc;
      pix_valid <= w_de_d & locked;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_bad       <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err         <= '0;
    end else begin
      frame_start <= w_vs_fall;
      err         <= (err & ~{3{err_clr}}) | w_err_set;
      unique case (r_state)
        SEARCH: begin
          if (w_vs_fall) begin
            r_state <= MEASURE;
            r_bad   <= 1'b0;
          end
        end
        MEASURE: begin
          if (w_vs_fall) begin
            r_bad <= 1'b0;
            if (!(r_bad | w_h_bad | w_len_bad | w_v_bad)) begin
              r_state <= LOCKED;
              locked  <= 1'b1;
            end
          end else if (w_h_bad | w_len_bad) begin
            r_bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (|w_err_set) begin
            r_state <= SEARCH;
            locked  <= 1'b0;
          end
        end
        default: begin
          r_state <= SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_RX_FRAME_SUM_EN
  logic [23:0] r_acc;
  logic [23:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (pix_valid ? pix_data : 24'd0);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      frame_sum <= '0;
    end else if (w_vs_fall) begin
      r_acc     <= '0;
      frame_sum <= w_acc_nxt;
    end else begin
      r_acc     <= w_acc_nxt;
    end
  end
`endif

endmodule
